// File: rtl/bp_fe_bht_ctrl.sv
// Access scheduler for a 1RW branch history table: arbitrates lookups against buffered counter updates.
// Optional statistics counters are built when BP_FE_BHT_CTRL_STATS_EN is defined; otherwise they read 0.
module bp_fe_bht_ctrl #(
  parameter int bht_idx_width_p = 9,
  parameter int fifo_els_p      = 4,
  parameter int max_starve_p    = 8,
  parameter int stat_width_p    = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  output logic                       pred_ready_o,
  output logic                       pred_v_o,
  input  logic                       upd_v_i,
  input  logic [bht_idx_width_p-1:0] upd_idx_i,
  input  logic                       upd_correct_i,
  output logic                       upd_ready_o,
  input  logic                       drain_i,
  output logic                       drain_done_o,
  output logic                       r_v_o,
  output logic [bht_idx_width_p-1:0] idx_r_o,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [stat_width_p-1:0]    stall_cnt_o,
  output logic [stat_width_p-1:0]    force_cnt_o
);

  localparam int ptr_w    = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w    = ptr_w + 1;
  localparam int starve_w = $clog2(max_starve_p + 1);

  localparam logic [cnt_w-1:0]    lp_full_cnt   = cnt_w'(fifo_els_p);
  localparam logic [starve_w-1:0] lp_starve_max = starve_w'(max_starve_p);

  typedef enum logic [1:0] {
    e_run   = 2'd0,
    e_drain = 2'd1,
    e_done  = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [bht_idx_width_p-1:0] r_fifo_idx  [fifo_els_p];
  logic                       r_fifo_corr [fifo_els_p];
  logic [ptr_w-1:0]           r_rd_ptr;
  logic [ptr_w-1:0]           r_wr_ptr;
  logic [cnt_w-1:0]           r_count;
  logic [cnt_w-1:0]           w_count_next;
  logic [starve_w-1:0]        r_starve_cnt;
  logic [starve_w-1:0]        w_starve_next;

  logic w_empty;
  logic w_full;
  logic w_enq;
  logic w_deq;
  logic w_force;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == lp_full_cnt);
  assign w_enq   = upd_v_i & upd_ready_o;
  assign w_deq   = w_v_o;

  // Lookup index passes straight through; write side always comes from the FIFO head.
  assign idx_r_o   = pred_idx_i;
  assign idx_w_o   = r_fifo_idx[r_rd_ptr];
  assign correct_o = r_fifo_corr[r_rd_ptr];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= e_run;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      e_run: begin
        if (drain_i) begin
          w_state_next = e_drain;
        end
      end
      e_drain: begin
        // Leave as soon as this cycle's write empties the FIFO (or it was already empty).
        if (w_count_next == '0) begin
          w_state_next = e_done;
        end
      end
      e_done: begin
        if (!drain_i) begin
          w_state_next = e_run;
        end
      end
      default: begin
        w_state_next = e_run;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / arbitration logic
  // ---------------------------------------------------------------------------
  always_comb begin
    r_v_o        = 1'b0;
    w_v_o        = 1'b0;
    pred_ready_o = 1'b0;
    upd_ready_o  = 1'b0;
    drain_done_o = 1'b0;
    w_force      = 1'b0;
    case (r_state)
      e_run: begin
        w_force     = ~w_empty & (w_full | (r_starve_cnt == lp_starve_max));
        upd_ready_o = ~w_full;
        if (w_force) begin
          w_v_o = 1'b1;
        end else begin
          pred_ready_o = 1'b1;
          if (pred_v_i) begin
            r_v_o = 1'b1;
          end else if (!w_empty) begin
            w_v_o = 1'b1;
          end
        end
      end
      e_drain: begin
        w_v_o = ~w_empty;
      end
      e_done: begin
        drain_done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Update FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    w_count_next = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_count_next = r_count + cnt_w'(1);
      2'b01:   w_count_next = r_count - cnt_w'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + ptr_w'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + ptr_w'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_fifo_idx[r_wr_ptr]  <= upd_idx_i;
      r_fifo_corr[r_wr_ptr] <= upd_correct_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter and read-valid pipeline
  // ---------------------------------------------------------------------------
  always_comb begin
    w_starve_next = r_starve_cnt;
    if (w_v_o || w_empty) begin
      w_starve_next = '0;
    end else if (r_v_o && (r_starve_cnt != lp_starve_max)) begin
      w_starve_next = r_starve_cnt + starve_w'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_starve_cnt <= '0;
      pred_v_o     <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_next;
      pred_v_o     <= r_v_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef BP_FE_BHT_CTRL_STATS_EN
  logic [stat_width_p-1:0] r_stall_cnt;
  logic [stat_width_p-1:0] r_force_cnt;
  logic                    w_stall;

  assign w_stall = pred_v_i & ~pred_ready_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_stall_cnt <= '0;
      r_force_cnt <= '0;
    end else begin
      if (w_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + stat_width_p'(1);
      end
      if (w_force && !(&r_force_cnt)) begin
        r_force_cnt <= r_force_cnt + stat_width_p'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign force_cnt_o = r_force_cnt;
`else
  assign stall_cnt_o = '0;
  assign force_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_fe_bht_ctrl.sv
// Self-checking bench for bp_fe_bht_ctrl: directed steps followed by randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_bp_fe_bht_ctrl;

  localparam int IDX_W  = 9;
  localparam int FIFO_N = 4;
  localparam int MAXS   = 8;
  localparam int STAT_W = 16;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_DONE  = 2;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              pred_v_i;
  logic [IDX_W-1:0]  pred_idx_i;
  logic              pred_ready_o;
  logic              pred_v_o;
  logic              upd_v_i;
  logic [IDX_W-1:0]  upd_idx_i;
  logic              upd_correct_i;
  logic              upd_ready_o;
  logic              drain_i;
  logic              drain_done_o;
  logic              r_v_o;
  logic [IDX_W-1:0]  idx_r_o;
  logic              w_v_o;
  logic [IDX_W-1:0]  idx_w_o;
  logic              correct_o;
  logic [STAT_W-1:0] stall_cnt_o;
  logic [STAT_W-1:0] force_cnt_o;

  always #5 clk_i = ~clk_i;

  bp_fe_bht_ctrl #(
    .bht_idx_width_p(IDX_W),
    .fifo_els_p     (FIFO_N),
    .max_starve_p   (MAXS),
    .stat_width_p   (STAT_W)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .pred_v_i     (pred_v_i),
    .pred_idx_i   (pred_idx_i),
    .pred_ready_o (pred_ready_o),
    .pred_v_o     (pred_v_o),
    .upd_v_i      (upd_v_i),
    .upd_idx_i    (upd_idx_i),
    .upd_correct_i(upd_correct_i),
    .upd_ready_o  (upd_ready_o),
    .drain_i      (drain_i),
    .drain_done_o (drain_done_o),
    .r_v_o        (r_v_o),
    .idx_r_o      (idx_r_o),
    .w_v_o        (w_v_o),
    .idx_w_o      (idx_w_o),
    .correct_o    (correct_o),
    .stall_cnt_o  (stall_cnt_o),
    .force_cnt_o  (force_cnt_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending updates as a queue, plus a drain mode and a starvation tally.
  int m_idx[$];
  bit m_cor[$];
  int m_mode;
  int m_starve;
  bit m_pred_v;
  int m_stall;
  int m_force;

  bit e_rv, e_wv, e_pr, e_ur, e_dd, e_frc;
  int dr_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_idx.delete();
    m_cor.delete();
    m_mode   = M_RUN;
    m_starve = 0;
    m_pred_v = 0;
    m_stall  = 0;
    m_force  = 0;
  endtask

  task automatic model_eval();
    bit empty, full;
    empty = (m_idx.size() == 0);
    full  = (m_idx.size() == FIFO_N);
    e_rv = 0; e_wv = 0; e_pr = 0; e_ur = 0; e_dd = 0; e_frc = 0;
    if (m_mode == M_RUN) begin
      e_ur  = !full;
      e_frc = !empty && (full || m_starve == MAXS);
      if (e_frc) begin
        e_wv = 1;
      end else begin
        e_pr = 1;
        if (pred_v_i) e_rv = 1;
        else if (!empty) e_wv = 1;
      end
    end else if (m_mode == M_DRAIN) begin
      e_wv = !empty;
    end else begin
      e_dd = 1;
    end
  endtask

  task automatic model_commit();
    bit empty;
    empty = (m_idx.size() == 0);
    if (pred_v_i && !e_pr && m_stall < (1 << STAT_W) - 1) m_stall++;
    if (e_frc && m_force < (1 << STAT_W) - 1) m_force++;
    if (e_wv || empty) m_starve = 0;
    else if (e_rv && m_starve < MAXS) m_starve++;
    if (e_wv) begin
      void'(m_idx.pop_front());
      void'(m_cor.pop_front());
    end
    if (upd_v_i && e_ur) begin
      m_idx.push_back(int'(upd_idx_i));
      m_cor.push_back(upd_correct_i);
    end
    m_pred_v = e_rv;
    case (m_mode)
      M_RUN:   if (drain_i) m_mode = M_DRAIN;
      M_DRAIN: if (m_idx.size() == 0) m_mode = M_DONE;
      default: if (!drain_i) m_mode = M_RUN;
    endcase
  endtask

  task automatic check_outputs();
    chk("pred_ready", 32'(pred_ready_o), 32'(e_pr));
    chk("upd_ready", 32'(upd_ready_o), 32'(e_ur));
    chk("r_v", 32'(r_v_o), 32'(e_rv));
    chk("w_v", 32'(w_v_o), 32'(e_wv));
    chk("drain_done", 32'(drain_done_o), 32'(e_dd));
    chk("pred_v_o", 32'(pred_v_o), 32'(m_pred_v));
    if (e_rv) chk("idx_r", 32'(idx_r_o), 32'(pred_idx_i));
    if (e_wv) begin
      chk("idx_w", 32'(idx_w_o), 32'(m_idx[0]));
      chk("correct", 32'(correct_o), 32'(m_cor[0]));
    end
`ifdef BP_FE_BHT_CTRL_STATS_EN
    chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
    chk("force_cnt", 32'(force_cnt_o), 32'(m_force));
`else
    chk("stall_cnt", 32'(stall_cnt_o), 32'd0);
    chk("force_cnt", 32'(force_cnt_o), 32'd0);
`endif
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk_i);
    model_eval();
    check_outputs();
    @(posedge clk_i);
    model_commit();
    #1;
  endtask

  task automatic set_in(input bit pv, input int pidx, input bit uv, input int uidx,
                        input bit uc, input bit dr);
    pred_v_i      = pv;
    pred_idx_i    = IDX_W'(pidx);
    upd_v_i       = uv;
    upd_idx_i     = IDX_W'(uidx);
    upd_correct_i = uc;
    drain_i       = dr;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    reset_n_i = 1'b0;
    #2;
    model_reset();
    chk("rst_pred_v_o", 32'(pred_v_o), 32'd0);
    chk("rst_pred_ready", 32'(pred_ready_o), 32'd1);
    chk("rst_upd_ready", 32'(upd_ready_o), 32'd1);
    chk("rst_r_v", 32'(r_v_o), 32'd0);
    chk("rst_w_v", 32'(w_v_o), 32'd0);
    chk("rst_drain_done", 32'(drain_done_o), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    chk("rst_force_cnt", 32'(force_cnt_o), 32'd0);
    reset_n_i = 1'b1;
    #1;
  endtask

  initial begin
    reset_n_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk_i);
    #1;
    do_reset();

    // Lookup straight after reset: read this cycle, valid prediction next cycle.
    set_in(1, 5, 0, 0, 0, 0);
    cycle();
    chk("t1_pred_v_o", 32'(pred_v_o), 32'd1);
    set_in(0, 0, 0, 0, 0, 0);
    cycle();

    // Four updates with no lookups: drained one per cycle in arrival order.
    for (int i = 1; i <= 4; i++) begin
      set_in(0, 0, 1, i, i[0], 0);
      cycle();
    end
    set_in(0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    // One queued update against continuous lookups: starvation bound forces the write.
    set_in(1, 9'h0a1, 1, 9'h033, 1, 0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      set_in(1, $urandom_range(0, 511), 0, 0, 0, 0);
      cycle();
    end
`ifdef BP_FE_BHT_CTRL_STATS_EN
    chk("t3_force_cnt", 32'(force_cnt_o), 32'd1);
    chk("t3_stall_cnt", 32'(stall_cnt_o), 32'd1);
`endif

    // Fill the FIFO while lookups never stop.
    for (int i = 0; i < 7; i++) begin
      set_in(1, $urandom_range(0, 511), 1, $urandom_range(0, 511), $urandom_range(0, 1), 0);
      cycle();
    end
    set_in(0, 0, 0, 0, 0, 0);
    repeat (6) cycle();

    // Three queued updates, then a full drain handshake.
    for (int i = 0; i < 3; i++) begin
      set_in(1, $urandom_range(0, 511), 1, 9'h100 + i, i[0], 0);
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1, $urandom_range(0, 511), 0, 0, 0, 1);
      cycle();
    end
    set_in(1, 9'h011, 0, 0, 0, 0);
    repeat (3) cycle();

    // Drain where drain_i drops mid-way: the drain still completes.
    for (int i = 0; i < 3; i++) begin
      set_in(1, $urandom_range(0, 511), 1, 9'h1f0 + i, 1, 0);
      cycle();
    end
    set_in(1, 0, 0, 0, 0, 1);
    cycle();
    set_in(0, 0, 0, 0, 0, 0);
    repeat (6) cycle();

    // Reset with pending updates discards them.
    for (int i = 0; i < 3; i++) begin
      set_in(1, $urandom_range(0, 511), 1, 9'h0c0 + i, 0, 0);
      cycle();
    end
    do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // Randomized traffic with occasional drains and resets.
    dr_left = 0;
    for (int n = 0; n < 1500; n++) begin
      bit dr;
      dr = 0;
      if (dr_left > 0) begin
        dr = 1;
        dr_left--;
      end else if ($urandom_range(0, 39) == 0) begin
        dr_left = $urandom_range(1, 8);
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        dr_left = 0;
      end
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 511),
             $urandom_range(0, 1) == 1, $urandom_range(0, 511),
             $urandom_range(0, 1) == 1, dr);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
